// File: rtl/cr_prefix_insert_gen_if.sv
// Bundle of every handshake/bus signal of cr_prefix_insert_gen.
//   cmd_*        : per-frame command (mode, prefix entry index, integrity-check enable)
//   ib_*         : payload input stream
//   ob_*         : merged output stream (prefix and payload words)
//   pfx_mem_*    : single-port prefix memory read port (1-cycle read latency)
//   pfx_err*     : integrity-check failure report
// Modports: slave = engine side, master = environment side (command source, payload source,
// output sink and prefix memory).
interface cr_prefix_insert_gen_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned NUM_W  = 6,
    parameter int unsigned ADDR_W = 9
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_mode;
    logic [NUM_W-1:0]  cmd_num;
    logic              cmd_check;

    logic              ib_valid;
    logic              ib_ready;
    logic [DATA_W-1:0] ib_data;
    logic              ib_last;

    logic              ob_valid;
    logic              ob_ready;
    logic [DATA_W-1:0] ob_data;
    logic              ob_last;
    logic              ob_is_pfx;

    logic              pfx_mem_cs;
    logic [ADDR_W-1:0] pfx_mem_addr;
    logic [DATA_W-1:0] pfx_mem_dout;

    logic              pfx_err;
    logic [NUM_W-1:0]  pfx_err_num;

    modport slave (
        input  cmd_valid, cmd_mode, cmd_num, cmd_check,
        input  ib_valid, ib_data, ib_last,
        input  ob_ready,
        input  pfx_mem_dout,
        output cmd_ready, ib_ready,
        output ob_valid, ob_data, ob_last, ob_is_pfx,
        output pfx_mem_cs, pfx_mem_addr,
        output pfx_err, pfx_err_num
    );

    modport master (
        output cmd_valid, cmd_mode, cmd_num, cmd_check,
        output ib_valid, ib_data, ib_last,
        output ob_ready,
        output pfx_mem_dout,
        input  cmd_ready, ib_ready,
        input  ob_valid, ob_data, ob_last, ob_is_pfx,
        input  pfx_mem_cs, pfx_mem_addr,
        input  pfx_err, pfx_err_num
    );
endinterface

// File: rtl/cr_prefix_insert_gen.sv
// Prefix insertion engine. For each accepted command it streams a stored prefix entry
// (PFX_WORDS words read from an external 1-cycle-latency memory) ahead of (prepend) or
// behind (append) the frame payload, or passes the payload through untouched (bypass).
// All output words go through a 4-entry FIFO; memory reads are credit-limited so that
// occupancy + inflight reads never exceeds the FIFO depth.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : cr_prefix_insert_gen_if.slave (command, payload in, output stream,
//              prefix memory read port, integrity error report)
module cr_prefix_insert_gen #(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned PFX_ENTRIES = 64,
    parameter int unsigned PFX_WORDS   = 8,
    parameter int unsigned NUM_W       = $clog2(PFX_ENTRIES),
    parameter int unsigned ADDR_W      = $clog2(PFX_ENTRIES * PFX_WORDS)
) (
    input logic                   clk,
    input logic                   rst,
    cr_prefix_insert_gen_if.slave bus
);
    localparam int unsigned IDX_W = (PFX_WORDS > 1) ? $clog2(PFX_WORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PFX_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StPfx, StPay, StApp} state_e;

    state_e            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [NUM_W-1:0]  num_q, num_d;
    logic              check_q, check_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              err_q, err_d;
    logic [NUM_W-1:0]  err_num_q, err_num_d;

    // Attributes of the read issued last cycle; captured at issue time because the
    // FSM may already have moved on (or accepted a new command) when the data returns.
    logic              inflight_q;
    logic              rd_final_q;
    logic              rd_app_q;
    logic              rd_check_q;
    logic [NUM_W-1:0]  rd_num_q;

    logic [DATA_W-1:0] fifo_data [4];
    logic              fifo_last [4];
    logic              fifo_pfx  [4];
    logic [1:0]        wr_ptr_q, rd_ptr_q;
    logic [2:0]        count_q;

    logic              push, pop;
    logic [DATA_W-1:0] push_data;
    logic              push_last, push_pfx;
    logic              credit, cs, ib_acc, cmd_acc, is_app, rd_final;

    assign is_app   = (mode_q == 2'd2);
    assign credit   = ({1'b0, count_q} + {3'b000, inflight_q}) < 4'd4;
    assign cs       = !rst && ((state_q == StPfx) || (state_q == StApp)) && credit;
    assign rd_final = (idx_q == IDX_LAST);

    assign bus.cmd_ready = !rst && (state_q == StIdle);
    // No payload while a prefix read is returning: keeps push sources exclusive.
    assign bus.ib_ready  = !rst && (state_q == StPay) && !inflight_q && (count_q < 3'd4);
    assign cmd_acc       = bus.cmd_valid && bus.cmd_ready;
    assign ib_acc        = bus.ib_valid && bus.ib_ready;

    assign bus.ob_valid  = !rst && (count_q != 3'd0);
    assign bus.ob_data   = fifo_data[rd_ptr_q];
    assign bus.ob_last   = bus.ob_valid && fifo_last[rd_ptr_q];
    assign bus.ob_is_pfx = bus.ob_valid && fifo_pfx[rd_ptr_q];
    assign pop           = bus.ob_valid && bus.ob_ready;

    assign bus.pfx_mem_cs   = cs;
    assign bus.pfx_mem_addr = cs ? (ADDR_W'(num_q) * ADDR_W'(PFX_WORDS) + ADDR_W'(idx_q))
                                 : '0;
    assign bus.pfx_err      = !rst && err_q;
    assign bus.pfx_err_num  = rst ? '0 : err_num_q;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        num_d     = num_q;
        check_d   = check_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        err_d     = 1'b0;
        err_num_d = err_num_q;
        push      = 1'b0;
        push_data = bus.pfx_mem_dout;
        push_last = 1'b0;
        push_pfx  = 1'b0;

        // Prefix word returning from memory.
        if (inflight_q) begin
            push      = 1'b1;
            push_data = bus.pfx_mem_dout;
            push_last = rd_app_q;
            push_pfx  = 1'b1;
            if (rd_check_q) begin
                if (rd_final_q) begin
                    err_d = |(acc_q ^ bus.pfx_mem_dout);
                    acc_d = '0;
                    if (err_d) begin
                        err_num_d = rd_num_q;
                    end
                end else begin
                    acc_d = acc_q ^ bus.pfx_mem_dout;
                end
            end
        end

        unique case (state_q)
            StIdle: begin
                if (cmd_acc) begin
                    mode_d  = bus.cmd_mode;
                    num_d   = bus.cmd_num;
                    check_d = bus.cmd_check;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = (bus.cmd_mode == 2'd1) ? StPfx : StPay;
                end
            end
            StPfx, StApp: begin
                if (cs) begin
                    if (rd_final) begin
                        idx_d   = '0;
                        state_d = (state_q == StPfx) ? StPay : StIdle;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            StPay: begin
                if (ib_acc) begin
                    push      = 1'b1;
                    push_data = bus.ib_data;
                    push_last = bus.ib_last && !is_app;
                    push_pfx  = 1'b0;
                    if (bus.ib_last) begin
                        state_d = is_app ? StApp : StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            mode_q     <= 2'd0;
            num_q      <= '0;
            check_q    <= 1'b0;
            idx_q      <= '0;
            acc_q      <= '0;
            err_q      <= 1'b0;
            err_num_q  <= '0;
            inflight_q <= 1'b0;
            rd_final_q <= 1'b0;
            rd_app_q   <= 1'b0;
            rd_check_q <= 1'b0;
            rd_num_q   <= '0;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            num_q      <= num_d;
            check_q    <= check_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            err_q      <= err_d;
            err_num_q  <= err_num_d;
            inflight_q <= cs;
            rd_final_q <= cs && rd_final;
            rd_app_q   <= cs && rd_final && (state_q == StApp);
            rd_check_q <= check_q;
            rd_num_q   <= num_q;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            count_q <= count_q + 3'(push) - 3'(pop);
        end
    end

    // FIFO storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr_q] <= push_data;
            fifo_last[wr_ptr_q] <= push_last;
            fifo_pfx[wr_ptr_q]  <= push_pfx;
        end
    end
endmodule

// File: tb/tb_cr_prefix_insert_gen.sv
// Directed bench for cr_prefix_insert_gen: prefix memory model, output monitor and one
// task per scenario with inline expected-value comparisons.
module tb_cr_prefix_insert_gen;
    localparam int unsigned DATA_W      = 64;
    localparam int unsigned PFX_ENTRIES = 64;
    localparam int unsigned PFX_WORDS   = 8;
    localparam int unsigned NUM_W       = 6;
    localparam int unsigned ADDR_W      = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cr_prefix_insert_gen_if #(.DATA_W(DATA_W), .NUM_W(NUM_W), .ADDR_W(ADDR_W)) bus ();

    cr_prefix_insert_gen #(
        .DATA_W     (DATA_W),
        .PFX_ENTRIES(PFX_ENTRIES),
        .PFX_WORDS  (PFX_WORDS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Prefix memory: data valid exactly one cycle after cs, poison otherwise.
    logic [DATA_W-1:0] mem [PFX_ENTRIES*PFX_WORDS];
    always @(posedge clk) begin
        bus.pfx_mem_dout <= bus.pfx_mem_cs ? mem[bus.pfx_mem_addr] : 64'hBAD0_BAD0_BAD0_BAD0;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Monitor state.
    logic [DATA_W-1:0] act_data [$];
    logic              act_last [$];
    logic              act_pfx  [$];
    int                act_cyc  [$];
    int                addr_q   [$];
    int                cs_cyc   [$];
    int                cs_cnt, err_cnt, level, max_level;
    logic [NUM_W-1:0]  err_num_seen;

    // Expected stream.
    logic [DATA_W-1:0] exp_data [$];
    logic              exp_last [$];
    logic              exp_pfx  [$];

    always @(negedge clk) begin
        if (rst) begin
            level = 0;
        end else begin
            if (bus.ob_valid && bus.ob_ready) begin
                act_data.push_back(bus.ob_data);
                act_last.push_back(bus.ob_last);
                act_pfx.push_back(bus.ob_is_pfx);
                act_cyc.push_back(cyc);
            end
            if (bus.pfx_mem_cs) begin
                cs_cnt++;
                addr_q.push_back(int'(bus.pfx_mem_addr));
                cs_cyc.push_back(cyc);
            end
            if (bus.pfx_err) begin
                err_cnt++;
                err_num_seen = bus.pfx_err_num;
            end
            // Words held or owed to the FIFO after the coming edge.
            level = level + int'(bus.pfx_mem_cs) + int'(bus.ib_valid && bus.ib_ready)
                    - int'(bus.ob_valid && bus.ob_ready);
            if (level > max_level) max_level = level;
        end
    end

    task automatic clear_mon();
        act_data.delete(); act_last.delete(); act_pfx.delete(); act_cyc.delete();
        addr_q.delete(); cs_cyc.delete();
        exp_data.delete(); exp_last.delete(); exp_pfx.delete();
        cs_cnt = 0; err_cnt = 0; max_level = 0;
    endtask

    task automatic exp_entry(input int num, input logic app);
        for (int i = 0; i < int'(PFX_WORDS); i++) begin
            exp_data.push_back(mem[num*PFX_WORDS + i]);
            exp_last.push_back(app && (i == int'(PFX_WORDS) - 1));
            exp_pfx.push_back(1'b1);
        end
    endtask

    task automatic exp_word(input logic [DATA_W-1:0] d, input logic last);
        exp_data.push_back(d);
        exp_last.push_back(last);
        exp_pfx.push_back(1'b0);
    endtask

    task automatic send_cmd(input logic [1:0] mode, input int num, input logic chk,
                            output int acc_cyc);
        bus.cmd_valid = 1'b1;
        bus.cmd_mode  = mode;
        bus.cmd_num   = NUM_W'(num);
        bus.cmd_check = chk;
        acc_cyc = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                acc_cyc = cyc;
                break;
            end
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        if (acc_cyc < 0) begin
            n_checks++;
            $display("FAIL cmd_accept: cmd_ready never seen, required 1 within 300 cycles");
        end
    endtask

    // Leaves ib_valid high so consecutive words stream at full rate.
    task automatic send_word(input logic [DATA_W-1:0] d, input logic last);
        bit ok = 0;
        bus.ib_valid = 1'b1;
        bus.ib_data  = d;
        bus.ib_last  = last;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.ib_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk); #1;
        if (!ok) begin
            n_checks++;
            $display("FAIL ib_accept: ib_ready never seen, required 1 within 300 cycles");
        end
    endtask

    task automatic wait_out(input int n);
        for (int i = 0; i < 400 && act_data.size() < n; i++) @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({bus.cmd_ready, bus.ib_ready, bus.ob_valid, bus.ob_last, bus.ob_is_pfx,
             bus.pfx_mem_cs, bus.pfx_err, bus.pfx_mem_addr, bus.pfx_err_num} !== '0)
            $display("FAIL reset_outputs: cmd_ready=%b ib_ready=%b ob_valid=%b cs=%b err=%b addr=%0d, required all 0",
                     bus.cmd_ready, bus.ib_ready, bus.ob_valid, bus.pfx_mem_cs, bus.pfx_err,
                     bus.pfx_mem_addr);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.cmd_ready !== 1'b1 || bus.ob_valid !== 1'b0)
            $display("FAIL reset_release: cmd_ready=%b ob_valid=%b, required 1 and 0",
                     bus.cmd_ready, bus.ob_valid);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_prepend();
        int t;
        clear_mon();
        exp_entry(3, 1'b0);
        exp_word(64'h1111_0000_0000_0001, 1'b0);
        exp_word(64'h1111_0000_0000_0002, 1'b1);
        send_cmd(2'd1, 3, 1'b0, t);
        send_word(64'h1111_0000_0000_0001, 1'b0);
        send_word(64'h1111_0000_0000_0002, 1'b1);
        bus.ib_valid = 1'b0;
        wait_out(10);
        n_checks++;
        if (act_data.size() !== 10)
            $display("FAIL prepend_count: got %0d words, required 10", act_data.size());
        else n_pass++;
        for (int i = 0; i < exp_data.size() && i < act_data.size(); i++) begin
            n_checks++;
            if ({act_data[i], act_last[i], act_pfx[i]} !== {exp_data[i], exp_last[i], exp_pfx[i]})
                $display("FAIL prepend_word%0d: got %h last=%b pfx=%b, required %h last=%b pfx=%b",
                         i, act_data[i], act_last[i], act_pfx[i], exp_data[i], exp_last[i], exp_pfx[i]);
            else n_pass++;
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (i >= addr_q.size() || addr_q[i] != 24 + i)
                $display("FAIL prepend_addr%0d: got %0d, required %0d", i,
                         (i < addr_q.size()) ? addr_q[i] : -1, 24 + i);
            else n_pass++;
        end
        n_checks++;
        if (cs_cyc.size() == 0 || cs_cyc[0] != t + 1)
            $display("FAIL prepend_first_cs: got cycle %0d, required %0d",
                     (cs_cyc.size() > 0) ? cs_cyc[0] : -1, t + 1);
        else n_pass++;
        n_checks++;
        if (act_cyc.size() == 0 || act_cyc[0] != t + 3)
            $display("FAIL prepend_first_valid: got cycle %0d, required %0d",
                     (act_cyc.size() > 0) ? act_cyc[0] : -1, t + 3);
        else n_pass++;
        n_checks++;
        if (act_cyc.size() < 10 || act_cyc[9] - act_cyc[0] > 10)
            $display("FAIL prepend_rate: span %0d cycles for %0d words, required <= 10 for 10",
                     (act_cyc.size() > 0) ? act_cyc[act_cyc.size()-1] - act_cyc[0] : -1,
                     act_cyc.size());
        else n_pass++;
        n_checks++;
        if (cs_cnt != 8 || err_cnt != 0)
            $display("FAIL prepend_cs_err: cs=%0d err=%0d, required 8 and 0", cs_cnt, err_cnt);
        else n_pass++;
    endtask

    task automatic test_append();
        int t;
        clear_mon();
        for (int i = 0; i < 3; i++) exp_word(64'h2222_0000_0000_0000 + 64'(i), 1'b0);
        exp_entry(0, 1'b1);
        send_cmd(2'd2, 0, 1'b0, t);
        for (int i = 0; i < 3; i++) send_word(64'h2222_0000_0000_0000 + 64'(i), i == 2);
        bus.ib_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.ib_ready !== 1'b0)
            $display("FAIL append_ib_ready: got %b after ib_last, required 0", bus.ib_ready);
        else n_pass++;
        @(posedge clk); #1;
        wait_out(11);
        n_checks++;
        if (act_data.size() !== 11)
            $display("FAIL append_count: got %0d words, required 11", act_data.size());
        else n_pass++;
        for (int i = 0; i < exp_data.size() && i < act_data.size(); i++) begin
            n_checks++;
            if ({act_data[i], act_last[i], act_pfx[i]} !== {exp_data[i], exp_last[i], exp_pfx[i]})
                $display("FAIL append_word%0d: got %h last=%b pfx=%b, required %h last=%b pfx=%b",
                         i, act_data[i], act_last[i], act_pfx[i], exp_data[i], exp_last[i], exp_pfx[i]);
            else n_pass++;
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (i >= addr_q.size() || addr_q[i] != i)
                $display("FAIL append_addr%0d: got %0d, required %0d", i,
                         (i < addr_q.size()) ? addr_q[i] : -1, i);
            else n_pass++;
        end
    endtask

    task automatic test_bypass();
        int t;
        logic [1:0] modes [2];
        modes[0] = 2'd0;
        modes[1] = 2'd3;
        for (int m = 0; m < 2; m++) begin
            clear_mon();
            for (int i = 0; i < 5; i++) exp_word(64'h3333_0000_0000_0000 + 64'(m*16 + i), i == 4);
            send_cmd(modes[m], 7, 1'b0, t);
            for (int i = 0; i < 5; i++) send_word(64'h3333_0000_0000_0000 + 64'(m*16 + i), i == 4);
            bus.ib_valid = 1'b0;
            wait_out(5);
            n_checks++;
            if (cs_cnt != 0 || act_data.size() != 5)
                $display("FAIL bypass_mode%0d: cs=%0d words=%0d, required 0 and 5",
                         modes[m], cs_cnt, act_data.size());
            else n_pass++;
            for (int i = 0; i < exp_data.size() && i < act_data.size(); i++) begin
                n_checks++;
                if ({act_data[i], act_last[i], act_pfx[i]} !== {exp_data[i], exp_last[i], exp_pfx[i]})
                    $display("FAIL bypass%0d_word%0d: got %h last=%b pfx=%b, required %h last=%b pfx=%b",
                             modes[m], i, act_data[i], act_last[i], act_pfx[i], exp_data[i],
                             exp_last[i], exp_pfx[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_integrity();
        int t;
        for (int pass = 0; pass < 2; pass++) begin
            clear_mon();
            if (pass == 1) mem[43] = mem[43] ^ 64'h0000_0100_0000_0000;
            exp_entry(5, 1'b0);
            exp_word(64'h4444_0000_0000_0000, 1'b1);
            send_cmd(2'd1, 5, 1'b1, t);
            send_word(64'h4444_0000_0000_0000, 1'b1);
            bus.ib_valid = 1'b0;
            wait_out(9);
            n_checks++;
            if (err_cnt != pass)
                $display("FAIL integrity_err_pulses%0d: got %0d, required %0d", pass, err_cnt, pass);
            else n_pass++;
            n_checks++;
            if (act_data.size() != 9)
                $display("FAIL integrity_count%0d: got %0d words, required 9", pass, act_data.size());
            else n_pass++;
            for (int i = 0; i < exp_data.size() && i < act_data.size(); i++) begin
                n_checks++;
                if ({act_data[i], act_last[i], act_pfx[i]} !== {exp_data[i], exp_last[i], exp_pfx[i]})
                    $display("FAIL integrity%0d_word%0d: got %h last=%b pfx=%b, required %h last=%b pfx=%b",
                             pass, i, act_data[i], act_last[i], act_pfx[i], exp_data[i],
                             exp_last[i], exp_pfx[i]);
                else n_pass++;
            end
            if (pass == 1) begin
                n_checks++;
                if (err_num_seen !== NUM_W'(5) || bus.pfx_err_num !== NUM_W'(5))
                    $display("FAIL integrity_err_num: pulse %0d held %0d, required 5",
                             err_num_seen, bus.pfx_err_num);
                else n_pass++;
                mem[43] = mem[43] ^ 64'h0000_0100_0000_0000;
            end
        end
    endtask

    task automatic test_back_to_back();
        int t;
        clear_mon();
        exp_entry(1, 1'b0);
        exp_word(64'h5555_0000_0000_0000, 1'b0);
        exp_word(64'h5555_0000_0000_0001, 1'b1);
        for (int i = 0; i < 3; i++) exp_word(64'h5555_0000_0000_0010 + 64'(i), 1'b0);
        exp_entry(2, 1'b1);
        exp_word(64'h5555_0000_0000_0020, 1'b0);
        exp_word(64'h5555_0000_0000_0021, 1'b1);
        exp_entry(4, 1'b0);
        exp_word(64'h5555_0000_0000_0030, 1'b1);
        fork
            begin
                bus.ob_ready = 1'b0;
                repeat (20) @(posedge clk);
                #1;
                for (int i = 0; i < 200; i++) begin
                    bus.ob_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                bus.ob_ready = 1'b1;
            end
            begin
                send_cmd(2'd1, 1, 1'b0, t);
                send_word(64'h5555_0000_0000_0000, 1'b0);
                send_word(64'h5555_0000_0000_0001, 1'b1);
                bus.ib_valid = 1'b0;
                send_cmd(2'd2, 2, 1'b0, t);
                for (int i = 0; i < 3; i++) send_word(64'h5555_0000_0000_0010 + 64'(i), i == 2);
                bus.ib_valid = 1'b0;
                send_cmd(2'd0, 9, 1'b0, t);
                send_word(64'h5555_0000_0000_0020, 1'b0);
                send_word(64'h5555_0000_0000_0021, 1'b1);
                bus.ib_valid = 1'b0;
                send_cmd(2'd1, 4, 1'b0, t);
                send_word(64'h5555_0000_0000_0030, 1'b1);
                bus.ib_valid = 1'b0;
            end
        join
        wait_out(32);
        n_checks++;
        if (max_level > 4 || max_level < 4)
            $display("FAIL bp_occupancy: peak buffered+inflight %0d, required 4", max_level);
        else n_pass++;
        n_checks++;
        if (act_data.size() != 32)
            $display("FAIL bp_count: got %0d words, required 32", act_data.size());
        else n_pass++;
        for (int i = 0; i < exp_data.size() && i < act_data.size(); i++) begin
            n_checks++;
            if ({act_data[i], act_last[i], act_pfx[i]} !== {exp_data[i], exp_last[i], exp_pfx[i]})
                $display("FAIL bp_word%0d: got %h last=%b pfx=%b, required %h last=%b pfx=%b",
                         i, act_data[i], act_last[i], act_pfx[i], exp_data[i], exp_last[i], exp_pfx[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int t;
        clear_mon();
        bus.ob_ready = 1'b0;
        send_cmd(2'd1, 6, 1'b0, t);
        // Four cycles later: three prefix words buffered, one read in flight.
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.cmd_ready, bus.ib_ready, bus.ob_valid, bus.ob_last, bus.ob_is_pfx,
             bus.pfx_mem_cs, bus.pfx_err, bus.pfx_mem_addr, bus.pfx_err_num} !== '0)
            $display("FAIL midreset_outputs: cmd_ready=%b ob_valid=%b cs=%b addr=%0d, required all 0",
                     bus.cmd_ready, bus.ob_valid, bus.pfx_mem_cs, bus.pfx_mem_addr);
        else n_pass++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.ob_ready = 1'b1;
        clear_mon();
        @(negedge clk);
        n_checks++;
        if (bus.ob_valid !== 1'b0 || bus.cmd_ready !== 1'b1)
            $display("FAIL midreset_release: ob_valid=%b cmd_ready=%b, required 0 and 1",
                     bus.ob_valid, bus.cmd_ready);
        else n_pass++;
        @(posedge clk); #1;
        exp_entry(2, 1'b0);
        exp_word(64'h6666_0000_0000_0000, 1'b1);
        send_cmd(2'd1, 2, 1'b0, t);
        send_word(64'h6666_0000_0000_0000, 1'b1);
        bus.ib_valid = 1'b0;
        wait_out(9);
        n_checks++;
        if (act_data.size() != 9)
            $display("FAIL midreset_count: got %0d words, required 9", act_data.size());
        else n_pass++;
        for (int i = 0; i < exp_data.size() && i < act_data.size(); i++) begin
            n_checks++;
            if ({act_data[i], act_last[i], act_pfx[i]} !== {exp_data[i], exp_last[i], exp_pfx[i]})
                $display("FAIL midreset_word%0d: got %h last=%b pfx=%b, required %h last=%b pfx=%b",
                         i, act_data[i], act_last[i], act_pfx[i], exp_data[i], exp_last[i], exp_pfx[i]);
            else n_pass++;
        end
    endtask

    initial begin
        logic [DATA_W-1:0] x;
        bus.cmd_valid = 1'b0;
        bus.cmd_mode  = 2'd0;
        bus.cmd_num   = '0;
        bus.cmd_check = 1'b0;
        bus.ib_valid  = 1'b0;
        bus.ib_data   = '0;
        bus.ib_last   = 1'b0;
        bus.ob_ready  = 1'b1;
        for (int i = 0; i < int'(PFX_ENTRIES * PFX_WORDS); i++) begin
            mem[i] = {32'(i) * 32'h9E37_79B1, 32'hC0DE_0000 | 32'(i)};
        end
        // Entry 5 is built to XOR to zero.
        x = '0;
        for (int i = 40; i < 47; i++) x = x ^ mem[i];
        mem[47] = x;

        test_reset();
        test_prepend();
        test_append();
        test_bypass();
        test_integrity();
        test_back_to_back();
        test_reset_mid();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
